dmem_responder: RTL and testbench

- Data-memory responder: the far end of the load/store interface driven by the core's decode/control logic (byte write strobes, func3 load type, address, store data).
- Accepts one request at a time over a valid/ready handshake and models a configurable access latency.
- Performs strobe-masked stores, or loads with byte/half/word extraction and sign/zero extension, and returns a response over a second valid/ready handshake.

---
 rtl/dmem_responder_pkg.sv | 15 +
 rtl/dmem_responder_load_align_ext.sv | 64 ++++++
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared load/store encodings and FSM state type for the data-memory responder.
package dmem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_WORD = 4'b1111;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

endpackage

// File: rtl/dmem_responder_load_align_ext.sv
// Load lane selection and sign/zero extension; flags illegal func3 and,
// when DMEM_MISALIGN_TRAP_EN is defined, misaligned half/word loads.
module load_align_ext
  import dmem_responder_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_data,
  output logic        o_err
);

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[8*i_addr +: 8];
  assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    case (i_func3)
      F3_LB:  o_data = sext8(w_byte);
      F3_LBU: o_data = {24'b0, w_byte};
      F3_LH: begin
        o_data = sext16(w_half);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (i_addr[0]) begin
          o_data = '0;
          o_err  = 1'b1;
        end
`endif
      end
      F3_LHU: begin
        o_data = {16'b0, w_half};
`ifdef DMEM_MISALIGN_TRAP_EN
        if (i_addr[0]) begin
          o_data = '0;
          o_err  = 1'b1;
        end
`endif
      end
      F3_LW: begin
        o_data = i_word;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (i_addr != 2'b00) begin
          o_data = '0;
          o_err  = 1'b1;
        end
`endif
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed access latency, strobed
// stores and extended loads. Optional misalignment trap: DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  dmem_state_t r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [3:0]    r_we;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_boff;
  logic [31:0]   r_wdata;
  logic [2:0]    r_func3;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_access;
  logic          w_in_idle;
  logic [3:0]    w_acc_we;
  logic [AW-1:0] w_acc_idx;
  logic [1:0]    w_acc_boff;
  logic [31:0]   w_acc_wdata;
  logic [2:0]    w_acc_func3;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_ld_data;
  logic          w_ld_err;
  logic          w_unused;

  assign w_unused  = ^req_addr[31:AW+2];
  assign w_in_idle = (r_state == IDLE);
  assign w_accept  = req_valid && r_req_ready;

  // With zero latency the access uses the live request on its acceptance edge.
  assign w_access = (w_accept && (LATENCY == 0)) || ((r_state == WAIT) && (r_cnt == 4'd1));

  assign w_acc_we    = w_in_idle ? req_we                  : r_we;
  assign w_acc_idx   = w_in_idle ? req_addr[AW+1:2]        : r_idx;
  assign w_acc_boff  = w_in_idle ? req_addr[1:0]           : r_boff;
  assign w_acc_wdata = w_in_idle ? req_wdata               : r_wdata;
  assign w_acc_func3 = w_in_idle ? req_func3               : r_func3;
  assign w_rd_word   = r_mem[w_acc_idx];

  load_align_ext u_align (
    .i_word  (w_rd_word),
    .i_addr  (w_acc_boff),
    .i_func3 (w_acc_func3),
    .o_data  (w_ld_data),
    .o_err   (w_ld_err)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_idx   <= req_addr[AW+1:2];
      r_boff  <= req_addr[1:0];
      r_wdata <= req_wdata;
      r_func3 <= req_func3;
    end
  end

  // w_access derives from reset state, so a reset drops any not-yet-done write.
  always_ff @(posedge clk) begin
    if (w_access) begin
      for (int n = 0; n < 4; n++) begin
        if (w_acc_we[n]) r_mem[w_acc_idx][8*n +: 8] <= w_acc_wdata[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt       <= LAT_CNT;
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: r_cnt <= r_cnt - 4'd1;
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_access) begin
        r_state     <= RESP;
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= (w_acc_we != WE_NONE) ? 32'd0 : w_ld_data;
        r_rsp_err   <= (w_acc_we != WE_NONE) ? 1'b0  : w_ld_err;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus random traffic
// against a byte-level reference memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv_a = 1'b0, rv_b = 1'b0;
  logic [3:0]  we = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [2:0]  f3 = '0;
  logic        rsp_ready = 1'b1;

  logic        qa_req_ready, qa_rsp_valid, qa_rsp_err;
  logic [31:0] qa_rsp_rdata;
  logic        qb_req_ready, qb_rsp_valid, qb_rsp_err;
  logic [31:0] qb_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl [1024];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(rv_a), .req_ready(qa_req_ready),
    .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_func3(f3),
    .rsp_valid(qa_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(qa_rsp_rdata), .rsp_err(qa_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(rv_b), .req_ready(qb_req_ready),
    .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_func3(f3),
    .rsp_valid(qb_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(qb_rsp_rdata), .rsp_err(qb_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load semantics computed arithmetically from the word contents.
  function automatic void ref_load(input logic [31:0] w, input logic [1:0] a,
                                   input logic [2:0] fn,
                                   output logic [31:0] d, output logic e);
    logic [31:0] b, h;
    logic mis;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    d = 0; e = 0; mis = 0;
    case (fn)
      3'b000: d = (b >= 128) ? b - 32'd256 : b;
      3'b100: d = b;
      3'b001: begin d = (h >= 32768) ? h - 32'd65536 : h; mis = a[0]; end
      3'b101: begin d = h; mis = a[0]; end
      3'b010: begin d = w; mis = (a != 0); end
      default: e = 1;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    if (mis) begin d = 0; e = 1; end
`endif
    if (e) d = 0;
  endfunction

  task automatic txn(input bit sel, input logic [3:0] t_we, input logic [31:0] t_addr,
                     input logic [31:0] t_wdata, input logic [2:0] t_f3,
                     output logic [31:0] rd, output logic e, output int cyc);
    logic v;
    @(negedge clk);
    we = t_we; addr = t_addr; wdata = t_wdata; f3 = t_f3; rsp_ready = 1'b1;
    if (sel) rv_b = 1'b1; else rv_a = 1'b1;
    @(posedge clk); #1;
    rv_a = 1'b0; rv_b = 1'b0;
    cyc = 1;
    v = sel ? qb_rsp_valid : qa_rsp_valid;
    while (v !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      v = sel ? qb_rsp_valid : qa_rsp_valid;
    end
    if (v !== 1'b1) chk("rsp_timeout", 32'(v), 32'd1);
    rd = sel ? qb_rsp_rdata : qa_rsp_rdata;
    e  = sel ? qb_rsp_err   : qa_rsp_err;
    @(posedge clk); #1;
    chk("ready_after_rsp", 32'(sel ? qb_req_ready : qa_req_ready), 32'd1);
    if (!sel) begin
      for (int n = 0; n < 4; n++)
        if (t_we[n]) mdl[t_addr[11:2]][8*n +: 8] = t_wdata[8*n +: 8];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_d, held, ra, rw;
    logic        e, exp_e;
    logic [3:0]  rwe;
    logic [2:0]  rf;
    int          cyc;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_req_ready", 32'(qa_req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(qa_rsp_valid), 32'd0);
    chk("reset_rsp_rdata", qa_rsp_rdata, 32'd0);
    chk("reset_rsp_err",   32'(qa_rsp_err), 32'd0);

    txn(0, 4'b1111, 32'h10, 32'hDEADBEEF, 3'b000, rd, e, cyc);
    chk("sw_latency", 32'(cyc), 32'd3);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_err", 32'(e), 32'd0);
    txn(0, 4'b0000, 32'h10, 32'h0, 3'b010, rd, e, cyc);
    chk("lw_10", rd, 32'hDEADBEEF);
    chk("lw_latency", 32'(cyc), 32'd3);

    txn(0, 4'b0100, 32'h10, 32'h00550000, 3'b000, rd, e, cyc);
    txn(0, 4'b0000, 32'h10, 32'h0, 3'b010, rd, e, cyc);
    chk("lw_strobe", rd, 32'hDE55BEEF);
    txn(0, 4'b0000, 32'h12, 32'h0, 3'b000, rd, e, cyc);
    chk("lb_12", rd, 32'h00000055);
    txn(0, 4'b0000, 32'h13, 32'h0, 3'b000, rd, e, cyc);
    chk("lb_13", rd, 32'hFFFFFFDE);
    txn(0, 4'b0000, 32'h13, 32'h0, 3'b100, rd, e, cyc);
    chk("lbu_13", rd, 32'h000000DE);
    txn(0, 4'b0000, 32'h12, 32'h0, 3'b001, rd, e, cyc);
    chk("lh_12", rd, 32'hFFFFDE55);
    txn(0, 4'b0000, 32'h10, 32'h0, 3'b101, rd, e, cyc);
    chk("lhu_10", rd, 32'h0000BEEF);

    txn(0, 4'b0000, 32'h11, 32'h0, 3'b010, rd, e, cyc);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lw_mis_data", rd, 32'd0);
    chk("lw_mis_err", 32'(e), 32'd1);
`else
    chk("lw_mis_data", rd, 32'hDE55BEEF);
    chk("lw_mis_err", 32'(e), 32'd0);
`endif
    txn(0, 4'b0000, 32'h10, 32'h0, 3'b011, rd, e, cyc);
    chk("illegal_f3_data", rd, 32'd0);
    chk("illegal_f3_err", 32'(e), 32'd1);

    // Backpressure on the response channel
    @(negedge clk);
    we = 4'b0000; addr = 32'h10; f3 = 3'b010; rsp_ready = 1'b0; rv_a = 1'b1;
    @(posedge clk); #1;
    rv_a = 1'b0;
    cyc = 1;
    while (qa_rsp_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("bp_rsp_rise", 32'(qa_rsp_valid), 32'd1);
    held = qa_rsp_rdata;
    chk("bp_first_data", held, 32'hDE55BEEF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", 32'(qa_rsp_valid), 32'd1);
      chk("bp_data_hold", qa_rsp_rdata, 32'hDE55BEEF);
      chk("bp_req_ready_low", 32'(qa_req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(qa_rsp_valid), 32'd0);
    chk("bp_release_ready", 32'(qa_req_ready), 32'd1);

    // Zero-latency instance
    txn(1, 4'b1111, 32'h40, 32'hCAFEF00D, 3'b000, rd, e, cyc);
    chk("lat0_sw_latency", 32'(cyc), 32'd1);
    txn(1, 4'b0000, 32'h40, 32'h0, 3'b010, rd, e, cyc);
    chk("lat0_lw_latency", 32'(cyc), 32'd1);
    chk("lat0_lw_data", rd, 32'hCAFEF00D);

    // Reset while a store is waiting
    txn(0, 4'b1111, 32'h20, 32'h12345678, 3'b000, rd, e, cyc);
    @(negedge clk);
    we = 4'b1111; addr = 32'h20; wdata = 32'hAABBCCDD; rv_a = 1'b1;
    @(posedge clk); #1;
    rv_a = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_wait_valid", 32'(qa_rsp_valid), 32'd0);
    chk("rst_wait_ready", 32'(qa_req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    txn(0, 4'b0000, 32'h20, 32'h0, 3'b010, rd, e, cyc);
    chk("rst_store_dropped", rd, 32'h12345678);

    // Address wrap
    txn(0, 4'b1111, 32'h1010, 32'h0BADF00D, 3'b000, rd, e, cyc);
    txn(0, 4'b0000, 32'h0010, 32'h0, 3'b010, rd, e, cyc);
    chk("wrap_readback", rd, 32'h0BADF00D);

    // Random traffic against the reference memory
    for (int i = 0; i < 16; i++)
      txn(0, 4'b1111, 32'(i * 4), $urandom, 3'b000, rd, e, cyc);
    for (int i = 0; i < 60; i++) begin
      ra  = 32'($urandom_range(0, 63));
      rw  = $urandom;
      rf  = 3'($urandom_range(0, 7));
      rwe = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      if (rwe == 4'b0000) ref_load(mdl[ra[11:2]], ra[1:0], rf, exp_d, exp_e);
      else begin exp_d = 0; exp_e = 0; end
      txn(0, rwe, ra, rw, rf, rd, e, cyc);
      chk("rand_data", rd, exp_d);
      chk("rand_err", 32'(e), 32'(exp_e));
      chk("rand_latency", 32'(cyc), 32'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
